forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 2: stored producer entries, i.e. the bypass stages behind EX.
- NUM_SRC, 2: number of consumer source ports.
- REG_W, 5: register index width.
- DATA_W, 32: data width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high.
- hold, in, 1: global pipeline freeze.
- flush, in, 1: squash the EX producer this cycle.
- ex_valid, in, 1: EX holds a register-writing producer.
- ex_dest, in, REG_W: producer destination register.
- ex_data, in, DATA_W: producer result (ALU result or link PC).
- ex_ready, in, 1: ex_data is final; 0 for loads.
- mem_load_valid, in, 1: load data is present for entry 0.
- mem_load_data, in, DATA_W: that load data.
- src_reg, in, NUM_SRC*REG_W: consumer source registers.
- src_used, in, NUM_SRC: per-source use flags.
- fwd_hit, out, NUM_SRC: forward taken for the source.
- fwd_data, out, NUM_SRC*DATA_W: forwarded value.
- stall, out, 1: load-use stall request.

Function
REQ-003 Each entry SHALL hold {valid, dest, data, ready}; entry 0 is youngest.
REQ-004 On an edge with hold=0, entry[i] SHALL take entry[i-1] for i>=1, and entry[0] SHALL take {ex_valid & ~flush & ~stall, ex_dest, ex_data, ex_ready}.
REQ-005 When stall=1 and hold=0, entry[0] SHALL load an invalid bubble while older entries still shift.
REQ-006 When hold=1, no entry SHALL shift; only the load fill of REQ-007 is applied, in place.
REQ-007 Load fill: if mem_load_valid & entry[0].valid & ~entry[0].ready, the copy of entry 0 written this edge (entry[1], or entry[0] under hold) SHALL get data=mem_load_data and ready=1.
REQ-008 When DEPTH=1 the shifted copy is dropped, but entry 0 SHALL still be filled in place under hold.
REQ-009 Lookup for source k SHALL be combinational, with zero-cycle latency.
REQ-010 The lookup SHALL select the lowest-index valid entry with dest==src_reg[k]; no match gives fwd_hit[k]=0.
REQ-011 src_reg[k]==0 or src_used[k]=0 SHALL always give fwd_hit[k]=0.
REQ-012 If the selected entry is ready, fwd_hit[k]=1 and fwd_data[k]=entry.data.
REQ-013 If the selected entry is entry 0, not ready, and mem_load_valid=1, fwd_hit[k]=1 and fwd_data[k]=mem_load_data (same-cycle load bypass).
REQ-014 Any other not-ready selection SHALL give fwd_hit[k]=0 and SHALL NOT fall through to an older entry.
REQ-015 fwd_data[k] SHALL be 0 whenever fwd_hit[k]=0.
REQ-016 ex_* inputs SHALL NOT be looked up in the same cycle; an EX-to-EX dependency is impossible by construction.

Reset
REQ-017 reset=1 SHALL clear every valid bit on the edge and SHALL take priority over hold, flush and load fill.
REQ-018 After reset, fwd_hit=0, fwd_data=0 and stall=0 until a valid entry is written.

Configuration
REQ-019 Macro FWD_LOAD_USE_STALL_EN SHALL control load-use stalling:
- Defined: stall=1 when any source hits the not-ready condition of REQ-014.
- Undefined: stall is tied 0 and the stall terms of REQ-004/005 are removed; the load-use case is treated as never occurring (software-scheduled).

Structure
REQ-020 The shared package fwd_pkg SHALL hold the default widths, the entry record layout and the zero-register constant.
REQ-021 Per-source priority match SHALL be the sub-module fwd_lookup, instantiated NUM_SRC times.
REQ-022 Entry storage and the stall OR-reduction SHALL stay in forward_scoreboard.

Verification
REQ-023 ALU chain: issue dest=8, data=0x11 (ready); next cycle src_reg[0]=8, used=1 -> fwd_hit[0]=1, fwd_data[0]=0x11.
REQ-024 Priority: issue dest=8 with 0xA, then dest=8 with 0xB; lookup of reg 8 -> 0xB.
REQ-025 Load-use (macro defined): load dest=9, not ready; next cycle src=9, mem_load_valid=0 -> stall=1, fwd_hit=0; next cycle data 0xCAFE filled -> fwd_hit=1, 0xCAFE, stall=0.
REQ-026 Same-cycle bypass: load dest=9 in entry 0 with mem_load_valid=1, data 0x55 -> fwd_hit=1, 0x55, stall=0.
REQ-027 Zero register: issue dest=0, data=0x77; lookup of reg 0 -> fwd_hit=0, fwd_data=0.
REQ-028 Hold/flush/reset: hold=1 for 3 cycles keeps dest=8 visible; flush with ex_valid=1 leaves no entry; reset mid-stream clears all hits the next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Forwarding scoreboard shared definitions.
// Default widths, entry record layout and the zero-register constant.
package fwd_pkg;

  localparam int FWD_DEPTH   = 2;
  localparam int FWD_NUM_SRC = 2;
  localparam int FWD_REG_W   = 5;
  localparam int FWD_DATA_W  = 32;

  localparam logic [FWD_REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_W-1:0]  dest;
    logic [FWD_DATA_W-1:0] data;
    logic                  ready;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Per-source priority match over the producer entries.
// Macro FWD_LOAD_USE_STALL_EN adds the pend (load-use) output.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int DEPTH  = FWD_DEPTH,
  parameter int REG_W  = FWD_REG_W,
  parameter int DATA_W = FWD_DATA_W
) (
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [DEPTH-1:0][REG_W-1:0]  ent_dest,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [DEPTH-1:0]             ent_ready,
  input  logic                         load_valid,
  input  logic [DATA_W-1:0]            load_data,
  input  logic [REG_W-1:0]             src,
  input  logic                         used,
  output logic                         hit,
`ifdef FWD_LOAD_USE_STALL_EN
  output logic                         pend,
`endif
  output logic [DATA_W-1:0]            data
);

  logic              found;
  logic              sel_ready;
  logic              sel_young;
  logic [DATA_W-1:0] sel_data;
  logic              active;

  // Youngest matching entry wins; a not-ready pick blocks older ones.
  always_comb begin
    found     = 1'b0;
    sel_ready = 1'b0;
    sel_young = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && ent_valid[i] && ent_dest[i] == src) begin
        found     = 1'b1;
        sel_ready = ent_ready[i];
        sel_young = (i == 0);
        sel_data  = ent_data[i];
      end
    end
    active = used && (src != REG_W'(ZERO_REG)) && found;
    hit  = 1'b0;
    data = '0;
`ifdef FWD_LOAD_USE_STALL_EN
    pend = 1'b0;
`endif
    if (active) begin
      if (sel_ready) begin
        hit  = 1'b1;
        data = sel_data;
      end else if (sel_young && load_valid) begin
        hit  = 1'b1;
        data = load_data;
      end else begin
`ifdef FWD_LOAD_USE_STALL_EN
        pend = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Bypass scoreboard: producer shift register plus per-source lookup.
// Macro FWD_LOAD_USE_STALL_EN enables load-use stall generation.
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter int DEPTH   = FWD_DEPTH,
  parameter int NUM_SRC = FWD_NUM_SRC,
  parameter int REG_W   = FWD_REG_W,
  parameter int DATA_W  = FWD_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [REG_W-1:0]          ex_dest,
  input  logic [DATA_W-1:0]         ex_data,
  input  logic                      ex_ready,
  input  logic                      mem_load_valid,
  input  logic [DATA_W-1:0]         mem_load_data,
  input  logic [NUM_SRC*REG_W-1:0]  src_reg,
  input  logic [NUM_SRC-1:0]        src_used,
  output logic [NUM_SRC-1:0]        fwd_hit,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic                      stall
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][REG_W-1:0]  dest_q, dest_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             ready_q, ready_d;

  logic fill;
  logic ex_take;

  assign fill = mem_load_valid & valid_q[0] & ~ready_q[0];

`ifdef FWD_LOAD_USE_STALL_EN
  logic [NUM_SRC-1:0] pend;
  assign stall   = |pend;
  assign ex_take = ex_valid & ~flush & ~stall;
`else
  assign stall   = 1'b0;
  assign ex_take = ex_valid & ~flush;
`endif

  // Shift producers older; under hold only fill entry 0 in place.
  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    data_d  = data_q;
    ready_d = ready_q;
    if (hold) begin
      if (fill) begin
        data_d[0]  = mem_load_data;
        ready_d[0] = 1'b1;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        dest_d[i]  = dest_q[i-1];
        data_d[i]  = data_q[i-1];
        ready_d[i] = ready_q[i-1];
        if (i == 1 && fill) begin
          data_d[i]  = mem_load_data;
          ready_d[i] = 1'b1;
        end
      end
      valid_d[0] = ex_take;
      dest_d[0]  = ex_dest;
      data_d[0]  = ex_data;
      ready_d[0] = ex_ready;
    end
  end

  // Entry storage; reset overrides hold, flush and fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dest_q  <= '0;
      data_q  <= '0;
      ready_q <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_lookup #(
      .DEPTH (DEPTH),
      .REG_W (REG_W),
      .DATA_W(DATA_W)
    ) u_lookup (
      .ent_valid (valid_q),
      .ent_dest  (dest_q),
      .ent_data  (data_q),
      .ent_ready (ready_q),
      .load_valid(mem_load_valid),
      .load_data (mem_load_data),
      .src       (src_reg[k*REG_W +: REG_W]),
      .used      (src_used[k]),
      .hit       (fwd_hit[k]),
`ifdef FWD_LOAD_USE_STALL_EN
      .pend      (pend[k]),
`endif
      .data      (fwd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard (default parameters).
// Expected stall on load-use follows FWD_LOAD_USE_STALL_EN.
module tb_forward_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_dest;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        mem_load_valid;
  logic [31:0] mem_load_data;
  logic [9:0]  src_reg;
  logic [1:0]  src_used;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic        stall;

`ifdef FWD_LOAD_USE_STALL_EN
  localparam logic LU = 1'b1;
`else
  localparam logic LU = 1'b0;
`endif

  typedef struct packed {
    int          id;
    logic [1:0]  hit;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        stl;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   next_id = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  forward_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .hold          (hold),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_dest       (ex_dest),
    .ex_data       (ex_data),
    .ex_ready      (ex_ready),
    .mem_load_valid(mem_load_valid),
    .mem_load_data (mem_load_data),
    .src_reg       (src_reg),
    .src_used      (src_used),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .stall         (stall)
  );

  task automatic idle();
    reset          = 1'b0;
    hold           = 1'b0;
    flush          = 1'b0;
    ex_valid       = 1'b0;
    ex_ready       = 1'b0;
    mem_load_valid = 1'b0;
    src_used       = 2'b00;
    check_en       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic ex(input logic [4:0] d, input logic [31:0] v,
                    input logic r);
    ex_valid = 1'b1;
    ex_dest  = d;
    ex_data  = v;
    ex_ready = r;
  endtask

  task automatic look(input logic [4:0] r0, input logic [4:0] r1,
                      input logic [1:0] u);
    src_reg  = {r1, r0};
    src_used = u;
  endtask

  task automatic expect_o(input logic [1:0] h, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
    exp_t e;
    e.id  = next_id;
    e.hit = h;
    e.d0  = a;
    e.d1  = b;
    e.stl = s;
    next_id++;
    exp_q.push_back(e);
    check_en = 1'b1;
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    if (check_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL queue_empty: output seen with no expectation");
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if (fwd_hit !== e.hit) begin
          n_fail++;
          $display("FAIL chk%0d hit: got %b want %b", e.id, fwd_hit, e.hit);
        end
        n_tests++;
        if (fwd_data[31:0] !== e.d0) begin
          n_fail++;
          $display("FAIL chk%0d data0: got %h want %h",
                   e.id, fwd_data[31:0], e.d0);
        end
        n_tests++;
        if (fwd_data[63:32] !== e.d1) begin
          n_fail++;
          $display("FAIL chk%0d data1: got %h want %h",
                   e.id, fwd_data[63:32], e.d1);
        end
        n_tests++;
        if (stall !== e.stl) begin
          n_fail++;
          $display("FAIL chk%0d stall: got %b want %b", e.id, stall, e.stl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset         = 1'b1;
    ex_dest       = '0;
    ex_data       = '0;
    mem_load_data = '0;
    src_reg       = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    idle();

    // reset state
    look(5'd8, 5'd8, 2'b11); expect_o(2'b00, 0, 0, 1'b0); tick();

    // ALU chain, then aging through entry 1
    ex(5'd8, 32'h11, 1'b1); tick();
    look(5'd8, 5'd8, 2'b11); expect_o(2'b11, 32'h11, 32'h11, 1'b0); tick();
    look(5'd8, 5'd0, 2'b01); expect_o(2'b01, 32'h11, 0, 1'b0); tick();
    look(5'd8, 5'd0, 2'b01); expect_o(2'b00, 0, 0, 1'b0); tick();

    // youngest producer wins
    ex(5'd8, 32'hA, 1'b1); tick();
    ex(5'd8, 32'hB, 1'b1);
    look(5'd8, 5'd0, 2'b01); expect_o(2'b01, 32'hA, 0, 1'b0); tick();
    look(5'd8, 5'd3, 2'b11); expect_o(2'b01, 32'hB, 0, 1'b0); tick();
    look(5'd8, 5'd0, 2'b01); expect_o(2'b01, 32'hB, 0, 1'b0); tick();

    // zero register never forwards
    ex(5'd0, 32'h77, 1'b1); tick();
    look(5'd0, 5'd0, 2'b11); expect_o(2'b00, 0, 0, 1'b0); tick();
    tick();

    // load-use: wait under hold, then bypass, then filled copy
    ex(5'd9, 32'hDEAD, 1'b0); tick();
    hold = 1'b1;
    look(5'd9, 5'd0, 2'b01); expect_o(2'b00, 0, 0, LU); tick();
    mem_load_valid = 1'b1; mem_load_data = 32'hCAFE;
    look(5'd9, 5'd9, 2'b11); expect_o(2'b11, 32'hCAFE, 32'hCAFE, 1'b0); tick();
    look(5'd9, 5'd0, 2'b01); expect_o(2'b01, 32'hCAFE, 0, 1'b0); tick();
    tick();

    // same-cycle bypass under hold fills entry 0 in place
    ex(5'd10, 32'h0, 1'b0); tick();
    hold = 1'b1; mem_load_valid = 1'b1; mem_load_data = 32'h55;
    look(5'd10, 5'd0, 2'b01); expect_o(2'b01, 32'h55, 0, 1'b0); tick();
    look(5'd10, 5'd0, 2'b01); expect_o(2'b01, 32'h55, 0, 1'b0); tick();
    tick();

    // not-ready young match blocks an older ready one
    ex(5'd9, 32'h1, 1'b1); tick();
    ex(5'd9, 32'h99, 1'b0); tick();
    look(5'd9, 5'd0, 2'b01); expect_o(2'b00, 0, 0, LU); tick();
    look(5'd9, 5'd0, 2'b01); expect_o(2'b00, 0, 0, LU); tick();

    // hold for three cycles keeps entry visible and ignores EX
    ex(5'd8, 32'h42, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      hold = 1'b1; ex(5'd8, 32'h99, 1'b1);
      look(5'd8, 5'd0, 2'b01); expect_o(2'b01, 32'h42, 0, 1'b0); tick();
    end
    look(5'd8, 5'd0, 2'b01); expect_o(2'b01, 32'h42, 0, 1'b0); tick();
    look(5'd8, 5'd0, 2'b01); expect_o(2'b01, 32'h42, 0, 1'b0); tick();

    // flush squashes the EX producer
    ex(5'd8, 32'h66, 1'b1); flush = 1'b1;
    look(5'd8, 5'd0, 2'b01); expect_o(2'b00, 0, 0, 1'b0); tick();
    look(5'd8, 5'd0, 2'b01); expect_o(2'b00, 0, 0, 1'b0); tick();

    // reset mid-stream clears everything on the edge
    ex(5'd8, 32'h5, 1'b1); tick();
    ex(5'd12, 32'h6, 1'b1); reset = 1'b1;
    look(5'd8, 5'd12, 2'b11); expect_o(2'b01, 32'h5, 0, 1'b0); tick();
    look(5'd8, 5'd12, 2'b11); expect_o(2'b00, 0, 0, 1'b0); tick();

    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d queued want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
